// File: rtl/sevenseg_capture.sv
// rtl/sevenseg_capture.sv - multiplexed seven-segment display sniffer that captures a decoded hex frame
//
// Purpose:
//   Watches the segment and digit-strobe lines of a multiplexed seven-segment
//   display. Each digit position is decoded once its pattern has been stable
//   for STABLE_CYCLES samples. When every position has been captured, the
//   frame is published on a valid/ready handshake.
//
// Parameters:
//   ZERO_IS_ON        1: segment lines are active-low and are inverted first
//   INVERSE_NUMBERING 0: bit6=a..bit0=g, 1: bit0=a..bit6=g
//   NUM_DIGITS        number of multiplexed digit positions (1..8)
//   STABLE_CYCLES     identical consecutive samples needed for a capture (1..255)
//
// Configuration macro:
//   SEVENSEG_CAPTURE_SYNC_EN  defined: 2-flop synchronizer on in_segs/in_sel
//                             undefined: pins are registered once as the sample
//
// Ports:
//   in_clk       clock, rising edge
//   in_rst_n     asynchronous active-low reset
//   in_segs      sniffed segment lines
//   in_sel       digit strobes, active-high, expected one-hot
//   out_digits   published frame, digit i at [4i+3:4i]
//   out_invalid  per-digit flag, captured pattern was not a legal glyph
//   out_valid    frame available
//   in_ready     consumer accepts the frame when high together with out_valid

module sevenseg_capture #(
  parameter int ZERO_IS_ON        = 0,
  parameter int INVERSE_NUMBERING = 0,
  parameter int NUM_DIGITS        = 4,
  parameter int STABLE_CYCLES     = 4
) (
  input  logic                    in_clk,
  input  logic                    in_rst_n,
  input  logic [6:0]              in_segs,
  input  logic [NUM_DIGITS-1:0]   in_sel,
  output logic [4*NUM_DIGITS-1:0] out_digits,
  output logic [NUM_DIGITS-1:0]   out_invalid,
  output logic                    out_valid,
  input  logic                    in_ready
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] SEG_XOR = (ZERO_IS_ON != 0) ? 7'h7f : 7'h00;

  // Glyph tables, entry k (digit value k) at bits [7k+6:7k].
  localparam logic [16*7-1:0] GLYPHS_STD = {
    7'h47, 7'h4f, 7'h3d, 7'h4e, 7'h1f, 7'h77, 7'h7b, 7'h7f,
    7'h70, 7'h5f, 7'h5b, 7'h33, 7'h79, 7'h6d, 7'h30, 7'h7e
  };
  localparam logic [16*7-1:0] GLYPHS_INV = {
    7'h71, 7'h79, 7'h5e, 7'h39, 7'h7c, 7'h77, 7'h6f, 7'h7f,
    7'h07, 7'h7d, 7'h6d, 7'h66, 7'h4f, 7'h5b, 7'h06, 7'h3f
  };
  localparam logic [16*7-1:0] GLYPHS = (INVERSE_NUMBERING != 0) ? GLYPHS_INV : GLYPHS_STD;

  // Returns {hit, nibble}; nibble is 0 when the pattern is not a glyph.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    logic [4:0] res;
    res = 5'd0;
    for (int k = 0; k < 16; k++) begin
      if (pat == GLYPHS[7*k +: 7]) begin
        res = {1'b1, 4'(k)};
      end
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Input stage: optional synchronizer, then active-low correction
  // ---------------------------------------------------------------------------
  logic [6:0]            pre_segs;
  logic [NUM_DIGITS-1:0] pre_sel;

`ifdef SEVENSEG_CAPTURE_SYNC_EN
  logic [6:0]            segs_s1, segs_s2;
  logic [NUM_DIGITS-1:0] sel_s1, sel_s2;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      segs_s1 <= '0;
      segs_s2 <= '0;
      sel_s1  <= '0;
      sel_s2  <= '0;
    end else begin
      segs_s1 <= in_segs;
      segs_s2 <= segs_s1;
      sel_s1  <= in_sel;
      sel_s2  <= sel_s1;
    end
  end

  assign pre_segs = segs_s2 ^ SEG_XOR;
  assign pre_sel  = sel_s2;
`else
  assign pre_segs = in_segs ^ SEG_XOR;
  assign pre_sel  = in_sel;
`endif

  // ---------------------------------------------------------------------------
  // Sample register and stability FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } state_t;

  state_t                state;
  logic [7:0]            cnt;
  logic                  cap_q;
  logic [6:0]            samp_segs;
  logic [NUM_DIGITS-1:0] samp_sel;
  logic                  sample_change;
  logic                  pre_onehot;

  // Change is judged against the value about to be loaded, so the counter
  // restarts at 1 on the same edge the new sample lands.
  assign sample_change = (pre_segs != samp_segs) || (pre_sel != samp_sel);
  assign pre_onehot    = $onehot(pre_sel);

  // cap_q is high exactly during the cycle in which the counter equals
  // STABLE_CYCLES while in SETTLE; the sample register then holds the
  // pattern that has been stable for STABLE_CYCLES samples.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 8'd0;
      cap_q     <= 1'b0;
      samp_segs <= '0;
      samp_sel  <= '0;
    end else begin
      samp_segs <= pre_segs;
      samp_sel  <= pre_sel;
      if (sample_change) begin
        if (pre_onehot) begin
          state <= ST_SETTLE;
          cnt   <= 8'd1;
          cap_q <= (STABLE_CYCLES == 1);
        end else begin
          state <= ST_IDLE;
          cnt   <= 8'd0;
          cap_q <= 1'b0;
        end
      end else begin
        case (state)
          ST_SETTLE: begin
            if (cap_q) begin
              state <= ST_HELD;
              cap_q <= 1'b0;
            end else begin
              cnt   <= cnt + 8'd1;
              cap_q <= (cnt == 8'(STABLE_CYCLES - 1));
            end
          end
          default: begin
            cap_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Capture datapath
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] cap_idx;
  logic [4:0]       dec;

  always_comb begin
    cap_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (samp_sel[i]) begin
        cap_idx = IDX_W'(i);
      end
    end
  end

  assign dec = decode(samp_segs);

  // ---------------------------------------------------------------------------
  // Working frame, mask and published frame
  // ---------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] slots;
  logic [NUM_DIGITS-1:0]   inv_w;
  logic [NUM_DIGITS-1:0]   mask;
  logic [NUM_DIGITS-1:0]   cap_bit;
  logic                    publish;

  // samp_sel is one-hot whenever cap_q is high, so it is the mask bit itself.
  assign cap_bit = cap_q ? samp_sel : '0;
  assign publish = (&mask) && !out_valid;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      slots       <= '0;
      inv_w       <= '0;
      mask        <= '0;
      out_digits  <= '0;
      out_invalid <= '0;
      out_valid   <= 1'b0;
    end else begin
      if (cap_q) begin
        slots[4*cap_idx +: 4] <= dec[3:0];
        inv_w[cap_idx]        <= ~dec[4];
      end
      // A capture landing on the publish edge belongs to the next frame.
      mask <= (publish ? '0 : mask) | cap_bit;
      if (publish) begin
        out_digits  <= slots;
        out_invalid <= inv_w;
        out_valid   <= 1'b1;
      end else if (out_valid && in_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_capture.sv
// tb/tb_sevenseg_capture.sv - directed self-checking bench for sevenseg_capture

module tb_sevenseg_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  segs;
  logic [3:0]  sel;
  logic [15:0] digits;
  logic [3:0]  invalid;
  logic        valid;
  logic        ready;

  int errors = 0;
  int checks = 0;

  logic [15:0] fr_d[$];
  logic [3:0]  fr_i[$];

  always #5 clk = ~clk;

  sevenseg_capture #(
    .ZERO_IS_ON       (0),
    .INVERSE_NUMBERING(0),
    .NUM_DIGITS       (4),
    .STABLE_CYCLES    (4)
  ) dut (
    .in_clk     (clk),
    .in_rst_n   (rst_n),
    .in_segs    (segs),
    .in_sel     (sel),
    .out_digits (digits),
    .out_invalid(invalid),
    .out_valid  (valid),
    .in_ready   (ready)
  );

  // Records every frame that will be accepted on the next rising edge.
  always @(negedge clk) begin
    #2;
    if (rst_n && valid && ready) begin
      fr_d.push_back(digits);
      fr_i.push_back(invalid);
    end
  end

  task automatic drive(input logic [3:0] s, input logic [6:0] g, input int n);
    sel  = s;
    segs = g;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    sel  = 4'b0000;
    segs = 7'h00;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sel   = 4'b0000;
    segs  = 7'h00;
    ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fr_d.delete();
    fr_i.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sel   = 4'b0000;
    segs  = 7'h00;
    ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++;
    if (digits !== 16'h0000) begin errors++; $display("FAIL reset_digits: got %h expected 0000", digits); end
    checks++;
    if (invalid !== 4'b0000) begin errors++; $display("FAIL reset_invalid: got %b expected 0000", invalid); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] got_d;
    logic [3:0]  got_i;
    do_reset();
    ready = 1'b1;
    drive(4'b0001, 7'h30, 6);
    drive(4'b0010, 7'h6d, 6);
    drive(4'b0100, 7'h79, 6);
    drive(4'b1000, 7'h33, 6);
    idle(6);
    got_d = (fr_d.size() > 0) ? fr_d[0] : 16'hxxxx;
    got_i = (fr_i.size() > 0) ? fr_i[0] : 4'hx;
    checks++;
    if (fr_d.size() !== 1) begin errors++; $display("FAIL basic_frames: got %0d expected 1", fr_d.size()); end
    checks++;
    if (got_d !== 16'h4321) begin errors++; $display("FAIL basic_digits: got %h expected 4321", got_d); end
    checks++;
    if (got_i !== 4'b0000) begin errors++; $display("FAIL basic_invalid: got %b expected 0000", got_i); end
  endtask

  task automatic test_latency();
    do_reset();
    ready = 1'b0;
    drive(4'b0001, 7'h30, 6);
    drive(4'b0010, 7'h6d, 6);
    drive(4'b0100, 7'h79, 6);
    drive(4'b1000, 7'h33, 5);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL latency_early: got valid=%b expected 0", valid); end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL latency_publish: got valid=%b expected 1", valid); end
    checks++;
    if (digits !== 16'h4321) begin errors++; $display("FAIL latency_digits: got %h expected 4321", digits); end
    idle(2);
  endtask

  task automatic test_boundary_hold();
    logic [15:0] got_d;
    do_reset();
    ready = 1'b1;
    drive(4'b0001, 7'h7e, 4);
    drive(4'b0010, 7'h6d, 4);
    drive(4'b0100, 7'h77, 4);
    drive(4'b1000, 7'h47, 4);
    idle(6);
    got_d = (fr_d.size() > 0) ? fr_d[0] : 16'hxxxx;
    checks++;
    if (got_d !== 16'hfa20) begin errors++; $display("FAIL boundary_digits: got %h expected fa20", got_d); end
  endtask

  task automatic test_glitch();
    logic [15:0] got_d;
    logic [3:0]  got_i;
    do_reset();
    ready = 1'b1;
    drive(4'b0010, 7'h30, 6);
    drive(4'b0100, 7'h6d, 6);
    drive(4'b1000, 7'h79, 6);
    drive(4'b0001, 7'h7f, 3);
    idle(8);
    checks++;
    if (fr_d.size() !== 0) begin errors++; $display("FAIL glitch_short_hold: got %0d frames expected 0", fr_d.size()); end
    drive(4'b0001, 7'h7f, 3);
    drive(4'b0001, 7'h7b, 6);
    idle(6);
    got_d = (fr_d.size() > 0) ? fr_d[0] : 16'hxxxx;
    got_i = (fr_i.size() > 0) ? fr_i[0] : 4'hx;
    checks++;
    if (fr_d.size() !== 1) begin errors++; $display("FAIL glitch_frames: got %0d expected 1", fr_d.size()); end
    checks++;
    if (got_d !== 16'h3219) begin errors++; $display("FAIL glitch_digits: got %h expected 3219", got_d); end
    checks++;
    if (got_i !== 4'b0000) begin errors++; $display("FAIL glitch_invalid: got %b expected 0000", got_i); end
  endtask

  task automatic test_illegal();
    logic [15:0] got_d;
    logic [3:0]  got_i;
    do_reset();
    ready = 1'b1;
    drive(4'b0001, 7'h30, 6);
    drive(4'b0010, 7'h00, 6);
    drive(4'b0100, 7'h79, 6);
    drive(4'b1000, 7'h33, 6);
    idle(6);
    got_d = (fr_d.size() > 0) ? fr_d[0] : 16'hxxxx;
    got_i = (fr_i.size() > 0) ? fr_i[0] : 4'hx;
    checks++;
    if (got_d !== 16'h4301) begin errors++; $display("FAIL illegal_digits: got %h expected 4301", got_d); end
    checks++;
    if (got_i !== 4'b0010) begin errors++; $display("FAIL illegal_invalid: got %b expected 0010", got_i); end
  endtask

  task automatic test_backpressure();
    logic [15:0] got_d;
    do_reset();
    ready = 1'b0;
    drive(4'b0001, 7'h33, 6);
    drive(4'b0010, 7'h79, 6);
    drive(4'b0100, 7'h6d, 6);
    drive(4'b1000, 7'h30, 6);
    idle(3);
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got %b expected 1", valid); end
    checks++;
    if (digits !== 16'h1234) begin errors++; $display("FAIL bp_first_digits: got %h expected 1234", digits); end
    drive(4'b0001, 7'h7f, 6);
    drive(4'b0010, 7'h70, 6);
    drive(4'b0100, 7'h5f, 6);
    drive(4'b1000, 7'h5b, 6);
    idle(4);
    checks++;
    if (digits !== 16'h1234) begin errors++; $display("FAIL bp_hold_digits: got %h expected 1234", digits); end
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b expected 1", valid); end
    ready = 1'b1;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL bp_handshake_clear: got %b expected 0", valid); end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid: got %b expected 1", valid); end
    checks++;
    if (digits !== 16'h5678) begin errors++; $display("FAIL bp_second_digits: got %h expected 5678", digits); end
    idle(3);
    got_d = (fr_d.size() > 1) ? fr_d[1] : 16'hxxxx;
    checks++;
    if (fr_d.size() !== 2) begin errors++; $display("FAIL bp_frames: got %0d expected 2", fr_d.size()); end
    checks++;
    if (got_d !== 16'h5678) begin errors++; $display("FAIL bp_second_accepted: got %h expected 5678", got_d); end
  endtask

  task automatic test_multihot();
    logic [15:0] got_d;
    do_reset();
    ready = 1'b1;
    drive(4'b0100, 7'h79, 6);
    drive(4'b1000, 7'h33, 6);
    drive(4'b0011, 7'h30, 10);
    idle(6);
    checks++;
    if (fr_d.size() !== 0) begin errors++; $display("FAIL multihot_no_frame: got %0d frames expected 0", fr_d.size()); end
    drive(4'b0001, 7'h30, 6);
    drive(4'b0010, 7'h6d, 6);
    idle(6);
    got_d = (fr_d.size() > 0) ? fr_d[0] : 16'hxxxx;
    checks++;
    if (fr_d.size() !== 1) begin errors++; $display("FAIL multihot_frames: got %0d expected 1", fr_d.size()); end
    checks++;
    if (got_d !== 16'h4321) begin errors++; $display("FAIL multihot_digits: got %h expected 4321", got_d); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] got_d;
    do_reset();
    ready = 1'b0;
    drive(4'b0001, 7'h30, 6);
    drive(4'b0010, 7'h30, 6);
    drive(4'b0100, 7'h30, 6);
    drive(4'b1000, 7'h30, 6);
    idle(3);
    checks++;
    if (digits !== 16'h1111) begin errors++; $display("FAIL midreset_pre_digits: got %h expected 1111", digits); end
    drive(4'b0001, 7'h70, 6);
    drive(4'b0010, 7'h70, 6);
    drive(4'b0100, 7'h70, 6);
    #2;
    rst_n = 1'b0;
    sel   = 4'b0000;
    segs  = 7'h00;
    #1;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL midreset_async_valid: got %b expected 0", valid); end
    checks++;
    if (digits !== 16'h0000) begin errors++; $display("FAIL midreset_async_digits: got %h expected 0000", digits); end
    @(negedge clk);
    rst_n = 1'b1;
    fr_d.delete();
    fr_i.delete();
    ready = 1'b1;
    drive(4'b0001, 7'h7e, 6);
    drive(4'b0010, 7'h30, 6);
    drive(4'b0100, 7'h6d, 6);
    drive(4'b1000, 7'h79, 6);
    idle(6);
    got_d = (fr_d.size() > 0) ? fr_d[0] : 16'hxxxx;
    checks++;
    if (fr_d.size() !== 1) begin errors++; $display("FAIL midreset_frames: got %0d expected 1", fr_d.size()); end
    checks++;
    if (got_d !== 16'h3210) begin errors++; $display("FAIL midreset_digits: got %h expected 3210", got_d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_boundary_hold();
    test_glitch();
    test_illegal();
    test_backpressure();
    test_multihot();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
